hdmi_timing_gen_param: RTL

Parametrised, runtime-reprogrammable video timing generator, successor to the fixed 720p sync generator. It produces HS/VS/DE, pixel coordinates and frame/line strobes from an Avalon-MM-programmed timing set. New timing is committed atomically at a frame boundary. All outputs pass through a configurable delay line so they align with downstream pixel pipelines. It sits between the CPU control bus and the pattern/pixel sources feeding the HDMI transmitter.

---
 rtl/hdmi_timing_gen_param_pkg.sv | 61 ++++++
 rtl/hdmi_timing_gen_param_if.sv | 22 ++
 rtl/hdmi_sync_delay.sv | 31 +++
 rtl/hdmi_timing_gen_param.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/hdmi_timing_gen_param_pkg.sv
// Shared constants and types for the parametrised HDMI timing generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: register addresses, CTRL/STATUS bit positions, 720p defaults,
// the timing_t field set and the commit validation helper.
package hdmi_timing_pkg;

    // Width of every timing field; the generator's CW parameter must match.
    localparam int TW = 12;

    localparam logic [3:0] A_CTRL   = 4'd0;
    localparam logic [3:0] A_H_ACT  = 4'd1;
    localparam logic [3:0] A_H_FP   = 4'd2;
    localparam logic [3:0] A_H_SY   = 4'd3;
    localparam logic [3:0] A_H_BP   = 4'd4;
    localparam logic [3:0] A_V_ACT  = 4'd5;
    localparam logic [3:0] A_V_FP   = 4'd6;
    localparam logic [3:0] A_V_SY   = 4'd7;
    localparam logic [3:0] A_V_BP   = 4'd8;
    localparam logic [3:0] A_COMMIT = 4'd9;
    localparam logic [3:0] A_STATUS = 4'd10;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_HS_POL = 1;
    localparam int CTRL_VS_POL = 2;
    localparam logic [2:0] CTRL_RST = 3'b111;

    localparam int ST_PEND   = 0;
    localparam int ST_ERR    = 1;
    localparam int ST_FC_LSB = 16;

    typedef struct packed {
        logic [TW-1:0] h_act;
        logic [TW-1:0] h_fp;
        logic [TW-1:0] h_sy;
        logic [TW-1:0] h_bp;
        logic [TW-1:0] v_act;
        logic [TW-1:0] v_fp;
        logic [TW-1:0] v_sy;
        logic [TW-1:0] v_bp;
    } timing_t;

    localparam timing_t DEF_TIMING = '{
        h_act: TW'(1280), h_fp: TW'(110), h_sy: TW'(40), h_bp: TW'(220),
        v_act: TW'(720),  v_fp: TW'(5),   v_sy: TW'(5),  v_bp: TW'(20)
    };

    // Largest legal line/frame total: 2^TW, held in TW+2 bits.
    localparam logic [TW+1:0] MAX_LEN = {2'b01, {TW{1'b0}}};

    function automatic logic timing_ok(timing_t t);
        logic [TW+1:0] hl;
        logic [TW+1:0] vl;
        hl = {2'b00, t.h_act} + {2'b00, t.h_fp} + {2'b00, t.h_sy} + {2'b00, t.h_bp};
        vl = {2'b00, t.v_act} + {2'b00, t.v_fp} + {2'b00, t.v_sy} + {2'b00, t.v_bp};
        return (t.h_act != '0) && (t.h_fp != '0) && (t.h_sy != '0) && (t.h_bp != '0) &&
               (t.v_act != '0) && (t.v_fp != '0) && (t.v_sy != '0) && (t.v_bp != '0) &&
               (hl <= MAX_LEN) && (vl <= MAX_LEN);
    endfunction

endpackage

// File: rtl/hdmi_timing_gen_param_if.sv
// Avalon-MM control bus between the CPU and the timing generator.
// Latency: reads answer one cycle after avs_read; writes land at the next edge.
// Backpressure: none, the slave never inserts wait states.
// Ports: address/read/write/writedata from master; readdata/readdatavalid back.
interface hdmi_timing_gen_param_if;
    logic [3:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata, avs_readdatavalid
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata, avs_readdatavalid
    );
endinterface

// File: rtl/hdmi_sync_delay.sv
// DEPTH-stage shift register aligning the video outputs with downstream pipes.
// Latency: DEPTH cycles; DEPTH=0 is a straight wire.
// Backpressure: none, shifts every cycle.
// Ports: clk, reset (sync, active-high), din -> dout; RST_VAL gives per-bit reset.
module hdmi_sync_delay #(
    parameter int           W       = 1,
    parameter int           DEPTH   = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);
    generate
        if (DEPTH == 0) begin : g_pass
            assign dout = din;
        end else begin : g_pipe
            logic [W-1:0] sr [DEPTH];
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) sr[i] <= RST_VAL;
                end else begin
                    sr[0] <= din;
                    for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
                end
            end
            assign dout = sr[DEPTH-1];
        end
    endgenerate
endmodule

// File: rtl/hdmi_timing_gen_param.sv
// Runtime-programmable video timing generator (HS/VS/DE, x/y, SOF/SOL, frame count).
// Latency: video outputs trail the counters by 1 + PIPE_DELAY cycles; reads take 1.
// Backpressure: none; free-running at the pixel clock, bus has no wait states.
// Ports: clk, reset (sync, active-high), avs (Avalon slave), vid_* video, frame_cnt.
module hdmi_timing_gen_param
    import hdmi_timing_pkg::*;
#(
    parameter int CW         = TW,
    parameter int PIPE_DELAY = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    hdmi_timing_gen_param_if.slave avs,
    output logic                   vid_hs,
    output logic                   vid_vs,
    output logic                   vid_de,
    output logic [CW-1:0]          vid_x,
    output logic [CW-1:0]          vid_y,
    output logic                   vid_sof,
    output logic                   vid_sol,
    output logic [15:0]            frame_cnt
);
    localparam int SW = TW + 2;
    localparam int DW = 5 + 2 * CW;
    localparam logic [DW-1:0] DL_RST = {~CTRL_RST[CTRL_HS_POL], ~CTRL_RST[CTRL_VS_POL],
                                        {(DW-2){1'b0}}};

    logic [2:0]    ctrl;
    timing_t       stage, live;
    logic          pending, commit_err;
    logic [CW-1:0] h, v;
    logic [31:0]   rd_mux;

    logic en, hs_pol, vs_pol;
    assign en     = ctrl[CTRL_EN];
    assign hs_pol = ctrl[CTRL_HS_POL];
    assign vs_pol = ctrl[CTRL_VS_POL];

    // Totals and region edges in TW+2 bits so sums of 2^TW-sized fields cannot wrap.
    logic [SW-1:0] h_w, v_w, ht, vt, hs_beg, hs_end, vs_beg, vs_end;
    assign h_w    = SW'(h);
    assign v_w    = SW'(v);
    assign ht     = SW'(live.h_act) + SW'(live.h_fp) + SW'(live.h_sy) + SW'(live.h_bp);
    assign vt     = SW'(live.v_act) + SW'(live.v_fp) + SW'(live.v_sy) + SW'(live.v_bp);
    assign hs_beg = SW'(live.h_act) + SW'(live.h_fp);
    assign hs_end = hs_beg + SW'(live.h_sy);
    assign vs_beg = SW'(live.v_act) + SW'(live.v_fp);
    assign vs_end = vs_beg + SW'(live.v_sy);

    logic line_end, frame_last, frame_end, xfer, commit_wr;
    assign line_end   = (h_w == ht - SW'(1));
    assign frame_last = line_end && (v_w == vt - SW'(1));
    assign frame_end  = en && frame_last;
    // With the generator stopped there is no frame boundary to wait for.
    assign xfer       = pending && (!en || frame_end);
    assign commit_wr  = avs.avs_write && (avs.avs_address == A_COMMIT);

    logic unused_wd;
    assign unused_wd = ^avs.avs_writedata[31:TW];

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl       <= CTRL_RST;
            stage      <= DEF_TIMING;
            live       <= DEF_TIMING;
            pending    <= 1'b0;
            commit_err <= 1'b0;
        end else begin
            // Transfer sees the staging value from before any write this cycle.
            if (xfer) begin
                live    <= stage;
                pending <= 1'b0;
            end
            if (avs.avs_write) begin
                case (avs.avs_address)
                    A_CTRL:  ctrl        <= avs.avs_writedata[2:0];
                    A_H_ACT: stage.h_act <= avs.avs_writedata[TW-1:0];
                    A_H_FP:  stage.h_fp  <= avs.avs_writedata[TW-1:0];
                    A_H_SY:  stage.h_sy  <= avs.avs_writedata[TW-1:0];
                    A_H_BP:  stage.h_bp  <= avs.avs_writedata[TW-1:0];
                    A_V_ACT: stage.v_act <= avs.avs_writedata[TW-1:0];
                    A_V_FP:  stage.v_fp  <= avs.avs_writedata[TW-1:0];
                    A_V_SY:  stage.v_sy  <= avs.avs_writedata[TW-1:0];
                    A_V_BP:  stage.v_bp  <= avs.avs_writedata[TW-1:0];
                    default: ;
                endcase
            end
            // A commit in the same cycle as a transfer re-arms pending.
            if (commit_wr) begin
                pending    <= timing_ok(stage);
                commit_err <= !timing_ok(stage);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h         <= '0;
            v         <= '0;
            frame_cnt <= '0;
        end else if (!en) begin
            h <= '0;
            v <= '0;
        end else if (line_end) begin
            h <= '0;
            if (frame_last) begin
                v         <= '0;
                frame_cnt <= frame_cnt + 16'd1;
            end else begin
                v <= v + CW'(1);
            end
        end else begin
            h <= h + CW'(1);
        end
    end

    always_comb begin
        rd_mux = '0;
        case (avs.avs_address)
            A_CTRL:   rd_mux = {29'd0, ctrl};
            A_H_ACT:  rd_mux = {{(32-TW){1'b0}}, stage.h_act};
            A_H_FP:   rd_mux = {{(32-TW){1'b0}}, stage.h_fp};
            A_H_SY:   rd_mux = {{(32-TW){1'b0}}, stage.h_sy};
            A_H_BP:   rd_mux = {{(32-TW){1'b0}}, stage.h_bp};
            A_V_ACT:  rd_mux = {{(32-TW){1'b0}}, stage.v_act};
            A_V_FP:   rd_mux = {{(32-TW){1'b0}}, stage.v_fp};
            A_V_SY:   rd_mux = {{(32-TW){1'b0}}, stage.v_sy};
            A_V_BP:   rd_mux = {{(32-TW){1'b0}}, stage.v_bp};
            A_STATUS: rd_mux = {frame_cnt, 14'd0, commit_err, pending};
            default:  rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            avs.avs_readdata      <= '0;
            avs.avs_readdatavalid <= 1'b0;
        end else begin
            avs.avs_readdata      <= avs.avs_read ? rd_mux : 32'd0;
            avs.avs_readdatavalid <= avs.avs_read;
        end
    end

    // Decode of the current counter state; everything is gated by enable.
    logic de_c, hs_c, vs_c, sof_c, sol_c;
    logic [CW-1:0] x_c, y_c;
    assign de_c  = en && (h_w < SW'(live.h_act)) && (v_w < SW'(live.v_act));
    assign hs_c  = (en && (h_w >= hs_beg) && (h_w < hs_end)) ^ ~hs_pol;
    assign vs_c  = (en && (v_w >= vs_beg) && (v_w < vs_end)) ^ ~vs_pol;
    assign sol_c = de_c && (h == '0);
    assign sof_c = sol_c && (v == '0);
    assign x_c   = de_c ? h : '0;
    assign y_c   = de_c ? v : '0;

    logic [DW-1:0] vid_q, vid_d;
    always_ff @(posedge clk) begin
        if (reset) vid_q <= DL_RST;
        else       vid_q <= {hs_c, vs_c, de_c, sof_c, sol_c, x_c, y_c};
    end

    hdmi_sync_delay #(.W(DW), .DEPTH(PIPE_DELAY), .RST_VAL(DL_RST)) u_dly (
        .clk   (clk),
        .reset (reset),
        .din   (vid_q),
        .dout  (vid_d)
    );

    assign {vid_hs, vid_vs, vid_de, vid_sof, vid_sol, vid_x, vid_y} = vid_d;

endmodule
